// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of the single-port data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: port 0 gets fixed priority instead of round-robin.
module dmem_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int DATA_W    = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              We0,
  input  logic              We1,
  input  logic [31:0]       Addr0,
  input  logic [31:0]       Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  input  logic              Lock0,
  input  logic              Lock1,
  output logic              Ack0,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              Busy,
  output logic              Owner,
  output logic [31:0]       MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [DATA_W-1:0] MemReadData
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(BURST_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t           state;
  logic             last_gnt;
  logic [CNT_W-1:0] burst_cnt;

  state_t tie_next;
  state_t exit0_next;
  state_t exit1_next;
  logic   hold0;
  logic   hold1;

  // A locked owner keeps the grant only while the burst is below its cap.
  assign hold0 = Lock0 && (burst_cnt < CNT_CAP);
  assign hold1 = Lock1 && (burst_cnt < CNT_CAP);

  always_comb begin
    tie_next   = IDLE;
    exit0_next = IDLE;
    exit1_next = IDLE;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    tie_next   = BUSY0;
    exit0_next = (Req1 && !Req0) ? BUSY1 : IDLE;
    exit1_next = Req0 ? BUSY0 : IDLE;
`else
    tie_next   = last_gnt ? BUSY0 : BUSY1;
    exit0_next = Req1 ? BUSY1 : IDLE;
    exit1_next = Req0 ? BUSY0 : IDLE;
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      RData0    <= '0;
      RData1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (Req0 && Req1) state <= tie_next;
          else if (Req0)    state <= BUSY0;
          else if (Req1)    state <= BUSY1;
        end
        BUSY0: begin
          last_gnt <= 1'b0;
          if (Req0 && !We0) RData0 <= MemReadData;
          if (hold0) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            burst_cnt <= '0;
            state     <= exit0_next;
          end
        end
        BUSY1: begin
          last_gnt <= 1'b1;
          if (Req1 && !We1) RData1 <= MemReadData;
          if (hold1) begin
            burst_cnt <= burst_cnt + 1'b1;
          end else begin
            burst_cnt <= '0;
            state     <= exit1_next;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  assign Ack0  = (state == BUSY0);
  assign Ack1  = (state == BUSY1);
  assign Busy  = (state != IDLE);
  assign Owner = (state == BUSY1);

  // Memory pins are quiet outside BUSY so an async reset aborts a write mid-cycle.
  always_comb begin
    MemAddress   = '0;
    MemWriteData = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    case (state)
      BUSY0: begin
        MemAddress   = Addr0;
        MemWriteData = WData0;
        MemWrite     = Req0 & We0;
        MemRead      = Req0 & ~We0;
      end
      BUSY1: begin
        MemAddress   = Addr1;
        MemWriteData = WData1;
        MemWrite     = Req1 & We1;
        MemRead      = Req1 & ~We1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed and randomized scoreboard bench for dmem_arbiter.
module tb_dmem_arbiter;

  localparam int BM = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        lock  [2];
  logic        ack   [2];
  logic [31:0] rdata [2];
  logic        Busy, Owner, MemWrite, MemRead;
  logic [31:0] MemAddress, MemWriteData, MemReadData;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        mem_ready = 1'b0;

  txn_t q0[$];
  txn_t q1[$];

  int n_cmp = 0;
  int n_err = 0;
  logic mon_en = 1'b0;
  logic        pend [2];
  logic [31:0] pend_exp [2];
  int last_p = -1;
  int run_len = 0;

  dmem_arbiter #(.BURST_MAX(BM), .DATA_W(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req0(req[0]), .Req1(req[1]), .We0(we[0]), .We1(we[1]),
    .Addr0(addr[0]), .Addr1(addr[1]), .WData0(wdata[0]), .WData1(wdata[1]),
    .Lock0(lock[0]), .Lock1(lock[1]), .Ack0(ack[0]), .Ack1(ack[1]),
    .RData0(rdata[0]), .RData1(rdata[1]), .Busy(Busy), .Owner(Owner),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] init_word(input int k);
    if (k == 4) return 32'hDEADBEEF;
    return 32'(k) * 32'h9E3779B1;
  endfunction

  // Memory model: asynchronous read, write committed on the rising edge.
  assign MemReadData = mem[MemAddress[11:2]];
  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 1024; k++) mem[k] <= init_word(k);
      mem_ready <= 1'b1;
    end else if (MemWrite) begin
      mem[MemAddress[11:2]] <= MemWriteData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic single_read(input int p, input logic [31:0] a, output logic [31:0] rd,
                             output int w, output logic [31:0] ma, output logic mr);
    logic done;
    req[p] = 1'b1; we[p] = 1'b0; addr[p] = a;
    w = 0; done = 1'b0; ma = '0; mr = 1'b0;
    while (!done && w < 20) begin
      @(negedge Clk);
      w++;
      done = ack[p];
      if (done) begin ma = MemAddress; mr = MemRead; end
    end
    if (!done) chk("read_timeout", 32'd0, 32'd1);
    tick();
    req[p] = 1'b0;
    @(negedge Clk);
    rd = rdata[p];
    tick();
  endtask

  task automatic tie_test(input int first);
    int second;
    second = 1 - first;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h24;
    @(negedge Clk);
    chk("tie_idle_cycle", 32'(Busy), 32'd0);
    @(negedge Clk);
    chk("tie_first_ack", 32'(ack[first]), 32'd1);
    chk("tie_first_other", 32'(ack[second]), 32'd0);
    tick();
    req[first] = 1'b0;
    @(negedge Clk);
    chk("tie_second_ack", 32'(ack[second]), 32'd1);
    chk("tie_second_owner", 32'(Owner), 32'(second));
    tick();
    req[second] = 1'b0;
    @(negedge Clk);
    chk("tie_release", 32'(Busy), 32'd0);
    tick();
  endtask

  task automatic run_port(input int p, input int n);
    logic chain;
    logic l;
    logic done;
    int   w;
    int   word;
    txn_t t;
    chain = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!chain) repeat ($urandom_range(0, 3)) tick();
      word    = 512 + p * 256 + int'($urandom_range(0, 255));
      t.we    = 1'($urandom_range(0, 1));
      t.addr  = 32'(word) << 2;
      t.wdata = $urandom;
      if (t.we) begin
        ref_mem[word] = t.wdata;
        t.rdata = t.wdata;
      end else begin
        t.rdata = ref_mem[word];
      end
      l = (k < n - 1) && ($urandom_range(0, 2) == 0);
      req[p] = 1'b1; we[p] = t.we; addr[p] = t.addr; wdata[p] = t.wdata; lock[p] = l;
      if (p == 0) q0.push_back(t); else q1.push_back(t);
      w = 0; done = 1'b0;
      while (!done && w < 40) begin
        @(negedge Clk);
        w++;
        done = ack[p];
      end
      if (!done) chk("req_timeout", 32'd0, 32'd1);
      else       chk("wait_bound", 32'(w - 1 <= BM + 1), 32'd1);
      tick();
      chain = l;
      if (!l) begin req[p] = 1'b0; lock[p] = 1'b0; end
    end
    req[p] = 1'b0; lock[p] = 1'b0;
  endtask

  // Scoreboard monitor: pops the expected transaction whenever a port is acknowledged.
  always @(negedge Clk) begin
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          chk("rdata", rdata[p], pend_exp[p]);
          pend[p] = 1'b0;
        end
      end
      chk("ack_exclusive", 32'(ack[0] & ack[1]), 32'd0);
      if (!ack[0] && !ack[1]) begin
        run_len = 0;
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          txn_t t;
          logic have;
          run_len = (last_p == p) ? run_len + 1 : 1;
          last_p  = p;
          chk("burst_cap", 32'(run_len > BM), 32'd0);
          chk("owner", 32'(Owner), 32'(p));
          if (req[p]) begin
            have = 1'b0;
            if (p == 0) begin
              if (q0.size() > 0) begin t = q0.pop_front(); have = 1'b1; end
            end else begin
              if (q1.size() > 0) begin t = q1.pop_front(); have = 1'b1; end
            end
            if (!have) begin
              chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
              chk("mem_address", MemAddress, t.addr);
              chk("mem_write", 32'(MemWrite), 32'(t.we));
              chk("mem_read", 32'(MemRead), 32'(!t.we));
              if (t.we) chk("mem_wdata", MemWriteData, t.wdata);
              else begin pend[p] = 1'b1; pend_exp[p] = t.rdata; end
            end
          end else begin
            chk("idle_lock_cycle", 32'({MemWrite, MemRead}), 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] ma;
    logic [31:0] wa;
    logic        mr;
    logic        got;
    int          w;
    int          wcnt;
    int          n0;
    logic        gap;
    logic        seen;
    logic        done;

    Reset_n = 1'b0;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0; lock[p] = 1'b0;
      pend[p] = 1'b0; pend_exp[p] = '0;
    end
    for (int k = 0; k < 1024; k++) ref_mem[k] = init_word(k);

    repeat (3) @(negedge Clk);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_acks", 32'({ack[0], ack[1]}), 32'd0);
    chk("reset_mem_ctrl", 32'({MemWrite, MemRead, Owner}), 32'd0);
    chk("reset_mem_addr", MemAddress, 32'd0);
    chk("reset_rdata0", rdata[0], 32'd0);
    chk("reset_rdata1", rdata[1], 32'd0);
    Reset_n = 1'b1;
    tick();

    single_read(0, 32'h10, rd, w, ma, mr);
    chk("read_latency", 32'(w), 32'd2);
    chk("read_addr", ma, 32'h10);
    chk("read_memread", 32'(mr), 32'd1);
    chk("read_data", rd, 32'hDEADBEEF);
    chk("read_rdata1_zero", rdata[1], 32'd0);

    tie_test(1);
    do_reset();
    @(negedge Clk);
    chk("reset_clears_rdata0", rdata[0], 32'd0);
    tick();
    tie_test(0);

    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h3FC; wdata[1] = 32'hA5A5A5A5;
    wcnt = 0; wa = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (MemWrite) begin wcnt++; wa = MemAddress; end
      got = ack[1];
      tick();
      if (got) begin req[1] = 1'b0; we[1] = 1'b0; end
    end
    chk("write_cycles", 32'(wcnt), 32'd1);
    chk("write_addr", wa, 32'h3FC);
    chk("write_committed", mem[255], 32'hA5A5A5A5);
    single_read(0, 32'h3FC, rd, w, ma, mr);
    chk("readback", rd, 32'hA5A5A5A5);

    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40; lock[0] = 1'b1;
    tick();
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h44;
    n0 = 0; gap = 1'b0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (ack[0]) n0++;
      else if (!ack[1]) gap = 1'b1;
      seen = ack[1];
      tick();
      if (n0 >= BM) begin req[0] = 1'b0; lock[0] = 1'b0; end
      if (seen) req[1] = 1'b0;
    end
    chk("lock_burst_len", 32'(n0), 32'(BM));
    chk("lock_no_gap", 32'(gap), 32'd0);
    chk("lock_handover", 32'(seen), 32'd1);
    @(negedge Clk);
    chk("lock_release_idle", 32'(Busy), 32'd0);
    tick();

    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h190; wdata[0] = 32'h12345678;
    w = 0; done = 1'b0;
    while (!done && w < 10) begin
      @(negedge Clk);
      w++;
      done = ack[0];
    end
    chk("abort_ack_seen", 32'(done), 32'd1);
    chk("abort_write_active", 32'(MemWrite), 32'd1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("abort_memwrite_drop", 32'(MemWrite), 32'd0);
    chk("abort_ack_drop", 32'(ack[0]), 32'd0);
    req[0] = 1'b0; we[0] = 1'b0;
    tick();
    chk("abort_no_commit", mem[100], init_word(100));
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("abort_idle_after", 32'(Busy), 32'd0);
    tick();

    mon_en = 1'b1;
    fork
      run_port(0, 80);
      run_port(1, 80);
    join
    repeat (4) tick();
    mon_en = 1'b0;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
